seq_detect: RTL and testbench

SEQ_DETECT -- requirements
Module: seq_detect

---
 rtl/seq_detect_pkg.sv | 14 +
 rtl/seq_detect_window.sv | 87 ++++++++
 rtl/seq_detect.sv | 86 ++++++++
 tb/tb_seq_detect.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and default constants for the serial pattern detector.
// Build option: SEQ_DETECT_COUNTER_EN enables the saturating match counter.
package seq_detect_pkg;

  localparam int         DEF_PAT_W   = 4;
  localparam int         DEF_CNT_W   = 8;
  localparam logic [3:0] DEF_PAT_RST = 4'b1101;

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_t;

endpackage

// File: rtl/seq_detect_window.sv
// History window, fill counter and FILL/ARMED state of the pattern detector.
// The window holds the last PAT_W-1 valid bits, newest in the LSB.
module seq_detect_window
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             load,
  input  logic             clr,
  input  logic             hit,
  input  logic             overlap,
  output logic [PAT_W-2:0] win,
  output logic             primed
);

  localparam int             FW   = $clog2(PAT_W);
  localparam logic [FW-1:0]  FULL = FW'(PAT_W - 1);

  state_t           state;
  state_t           state_nx;
  logic [FW-1:0]    fill;
  logic [FW-1:0]    fill_nx;
  logic [PAT_W-2:0] win_nx;
  logic [PAT_W-1:0] shifted;

  assign shifted = {win, x};
  assign primed  = (state == ARMED);

  // State, fill and window registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      fill  <= '0;
      win   <= '0;
    end else begin
      state <= state_nx;
      fill  <= fill_nx;
      win   <= win_nx;
    end
  end

  // Next-state logic; clr and load both restart filling and drop the bit.
  always_comb begin
    state_nx = state;
    fill_nx  = fill;
    win_nx   = win;
    if (clr) begin
      state_nx = FILL;
      fill_nx  = '0;
      win_nx   = '0;
    end else if (load) begin
      state_nx = FILL;
      fill_nx  = '0;
    end else if (en) begin
      win_nx = shifted[PAT_W-2:0];
      if (hit && !overlap) begin
        // Non-overlapping mode: the matched bits must not seed the next match.
        state_nx = FILL;
        fill_nx  = '0;
      end else begin
        case (state)
          FILL: begin
            fill_nx  = fill + FW'(1);
            state_nx = (fill_nx == FULL) ? ARMED : FILL;
          end
          ARMED: begin
            fill_nx  = fill;
            state_nx = ARMED;
          end
          default: begin
            fill_nx  = '0;
            state_nx = FILL;
          end
        endcase
      end
    end else begin
      state_nx = state;
      fill_nx  = fill;
      win_nx   = win;
    end
  end

endmodule

// File: rtl/seq_detect.sv
// Serial pattern detector top: target pattern, compare, match pulse, counter.
// Build option: SEQ_DETECT_COUNTER_EN enables count; otherwise count is 0.
module seq_detect
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter int               CNT_W   = DEF_CNT_W,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(DEF_PAT_RST)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  input  logic             clr,
  output logic             match,
  output logic [CNT_W-1:0] count,
  output logic             primed
);

  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-2:0] win;
  logic             hit;

  // A bit coinciding with load or clr is discarded and can never complete a match.
  assign hit = en & primed & ~load & ~clr & ({win, x} == pat_q);

  seq_detect_window #(
    .PAT_W(PAT_W)
  ) u_window (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .x       (x),
    .load    (load),
    .clr     (clr),
    .hit     (hit),
    .overlap (overlap),
    .win     (win),
    .primed  (primed)
  );

  // Target pattern register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q <= PAT_RST;
    end else if (load) begin
      pat_q <= pat_in;
    end else begin
      pat_q <= pat_q;
    end
  end

  // One-cycle match pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match <= 1'b0;
    end else begin
      match <= hit;
    end
  end

`ifdef SEQ_DETECT_COUNTER_EN
  logic [CNT_W-1:0] cnt;

  // Saturating match counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (hit && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign count = cnt;
`else
  assign count = '0;
`endif

endmodule

// File: tb/tb_seq_detect.sv
// Directed-vector bench for seq_detect (PAT_W=4, pattern 1101).
// Two instances share stimulus: CNT_W=8 and CNT_W=2 for saturation.
module tb_seq_detect;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       x;
  logic       load;
  logic [3:0] pat_in;
  logic       overlap;
  logic       clr;
  logic       m1, p1, m2, p2;
  logic [7:0] c1;
  logic [1:0] c2;

  int n_vec  = 0;
  int n_miss = 0;

`ifdef SEQ_DETECT_COUNTER_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  seq_detect #(.PAT_W(4), .CNT_W(8), .PAT_RST(4'b1101)) u1 (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat_in),
    .overlap(overlap), .clr(clr), .match(m1), .count(c1), .primed(p1)
  );

  seq_detect #(.PAT_W(4), .CNT_W(2), .PAT_RST(4'b1101)) u2 (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat_in),
    .overlap(overlap), .clr(clr), .match(m2), .count(c2), .primed(p2)
  );

  // Expected counter value: zero when the counter is compiled out.
  function automatic logic [31:0] ec(input int n);
    return CNT_ON ? 32'(n) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Feed n bits MSB first; expm gives the expected match after each bit.
  task automatic shift_in(input string tag, input logic [31:0] bits, input int n,
                          input logic [31:0] expm);
    for (int i = n - 1; i >= 0; i--) begin
      en = 1'b1;
      x  = bits[i];
      @(posedge clk);
      #1;
      chk($sformatf("%s_b%0d", tag, n - i), {31'd0, m1}, {31'd0, expm[i]});
    end
    en = 1'b0;
    x  = 1'b0;
  endtask

  task automatic do_clr(input string tag);
    clr = 1'b1;
    en  = 1'b1;
    x   = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_m"}, {31'd0, m1}, 32'd0);
    chk({tag, "_p"}, {31'd0, p1}, 32'd0);
    chk({tag, "_c"}, {24'd0, c1}, 32'd0);
    clr = 1'b0;
    en  = 1'b0;
    x   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; x = 1'b0; load = 1'b0; clr = 1'b0;
    overlap = 1'b1; pat_in = 4'b0000;
    #12;
    chk("rst_m", {31'd0, m1}, 32'd0);
    chk("rst_c", {24'd0, c1}, 32'd0);
    chk("rst_p", {31'd0, p1}, 32'd0);
    chk("rst_c2", {30'd0, c2}, 32'd0);
    rst = 1'b0;

    // Overlapping: 1101101 matches after bits 4 and 7.
    shift_in("ov1", 32'b1101101, 7, 32'b0001001);
    chk("ov1_c", {24'd0, c1}, ec(2));

    // Non-overlapping: bits after a hit start a fresh fill.
    do_clr("clr_a");
    overlap = 1'b0;
    shift_in("ov0a", 32'b1101101, 7, 32'b0001000);
    chk("ov0a_c", {24'd0, c1}, ec(1));
    do_clr("clr_b");
    shift_in("ov0b", 32'b11011101, 8, 32'b00010001);
    chk("ov0b_c", {24'd0, c1}, ec(2));

    // 110101 yields only the first match in either mode.
    do_clr("clr_c");
    shift_in("t6o0", 32'b110101, 6, 32'b000100);
    chk("t6o0_c", {24'd0, c1}, ec(1));
    do_clr("clr_d");
    overlap = 1'b1;
    shift_in("t6o1", 32'b110101, 6, 32'b000100);
    chk("t6o1_c", {24'd0, c1}, ec(1));

    // en gap: the x=0 presented with en=0 is ignored.
    do_clr("clr_e");
    shift_in("gap_a", 32'b11, 2, 32'b00);
    en = 1'b0;
    x  = 1'b0;
    @(posedge clk);
    #1;
    chk("gap_idle_m", {31'd0, m1}, 32'd0);
    chk("gap_idle_p", {31'd0, p1}, 32'd0);
    shift_in("gap_b", 32'b01, 2, 32'b01);
    chk("gap_c", {24'd0, c1}, ec(1));

    // Load of 0110 with a coincident valid bit discards that bit.
    do_clr("clr_f");
    shift_in("ld_pre", 32'b011, 3, 32'b000);
    chk("ld_pre_p", {31'd0, p1}, 32'd1);
    load   = 1'b1;
    pat_in = 4'b0110;
    en     = 1'b1;
    x      = 1'b0;
    @(posedge clk);
    #1;
    chk("ld_m", {31'd0, m1}, 32'd0);
    chk("ld_p", {31'd0, p1}, 32'd0);
    load = 1'b0;
    en   = 1'b0;
    shift_in("ld_pat", 32'b0110, 4, 32'b0001);

    // Reset mid-pattern restores 1101 and requires a full fresh fill.
    do_clr("clr_g");
    shift_in("rs_pre", 32'b110, 3, 32'b000);
    rst = 1'b1;
    #2;
    chk("rs_m", {31'd0, m1}, 32'd0);
    chk("rs_c", {24'd0, c1}, 32'd0);
    chk("rs_p", {31'd0, p1}, 32'd0);
    rst = 1'b0;
    shift_in("rs_one", 32'b1, 1, 32'b0);
    shift_in("rs_pat", 32'b101, 3, 32'b001);
    chk("rs_pat_c", {24'd0, c1}, ec(1));

    // Five overlapping hits: 2-bit counter saturates at 3.
    do_clr("clr_h");
    shift_in("sat", 32'b1101101101101101, 16, 32'b0001001001001001);
    chk("sat_c1", {24'd0, c1}, ec(5));
    chk("sat_c2", {30'd0, c2}, ec(3));
    chk("sat_p2", {31'd0, p2}, 32'd1);
    do_clr("clr_i");
    chk("sat_clr_c2", {30'd0, c2}, 32'd0);
    chk("sat_clr_p2", {31'd0, p2}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
